// File: rtl/ahb_subordinate_mem_if.sv
// AHB-Lite bus bundle between one manager and one subordinate.
//   master modport : drives address/control/write data and the bus-level HREADY
//   slave  modport : drives HREADYOUT, HRESP and HRDATA
// HCLK and HRESETn are carried as plain ports on the modules.
interface ahb_subordinate_mem_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [3:0]  HWSTRB;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK,
           HWDATA, HWSTRB, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK,
           HWDATA, HWSTRB, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_subordinate_mem.sv
// AHB-Lite subordinate backed by a flop-based 32-bit word memory.
// Inserts WAIT_STATES wait cycles before each OKAY data phase and gives the
// two-cycle ERROR response for out-of-range, misaligned or non-word transfers.
// Ports:
//   HCLK     bus clock, all state on the rising edge
//   HRESETn  asynchronous active-low reset
//   bus      ahb_subordinate_mem_if.slave (address/control/data in,
//            HREADYOUT/HRESP/HRDATA out)
//
// state  | meaning
// S_IDLE | no data phase pending (ready, OKAY)
// S_WAIT | wait-state down-counter running (not ready, OKAY)
// S_DATA | final data-phase cycle; write commits / read data driven
// S_ERR1 | first ERROR cycle (not ready, ERROR)
// S_ERR2 | second ERROR cycle (ready, ERROR)
module ahb_subordinate_mem #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic                  HCLK,
  input logic                  HRESETn,
  ahb_subordinate_mem_if.slave bus
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SPAN    = 32'(DEPTH * 4);
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [2:0]  SIZE_WORD = 3'b010;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t          state;
  logic [3:0]      wait_cnt;
  logic            wr_q;
  logic [AW-1:0]   idx_q;
  logic            hreadyout_q;
  logic            hresp_q;
  logic [31:0]     hrdata_q;

  logic [31:0]     mem [DEPTH];

  logic [31:0]     offset;
  logic            addr_err;
  logic            accept;
  logic [AW-1:0]   idx_in;
  logic            wr_commit;
  logic [31:0]     merged;

  assign offset   = bus.HADDR - BASE_ADDR;
  assign addr_err = (bus.HADDR < BASE_ADDR) || (offset >= SPAN) ||
                    (bus.HADDR[1:0] != 2'b00) || (bus.HSIZE != SIZE_WORD);
  assign idx_in   = offset[AW+1:2];

  // Our own ready gates accept too, so nothing is taken during WAIT/ERR1
  // even if the bus-level HREADY is wired loosely.
  assign accept    = bus.HSEL && bus.HREADY && bus.HTRANS[1] && hreadyout_q;
  assign wr_commit = (state == S_DATA) && wr_q;

  // Current word with the data-phase byte lanes applied; used both for the
  // commit and to forward into a back-to-back read of the same word.
  always_comb begin
    merged = mem[idx_q];
    for (int i = 0; i < 4; i++) begin
      if (bus.HWSTRB[i]) merged[8*i +: 8] = bus.HWDATA[8*i +: 8];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= S_IDLE;
      wait_cnt    <= 4'd0;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= 32'h0;
    end else begin
      hrdata_q <= 32'h0;
      unique case (state)
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state       <= S_DATA;
            hreadyout_q <= 1'b1;
            if (!wr_q) hrdata_q <= mem[idx_q];
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          state       <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          hresp_q     <= 1'b0;
          hreadyout_q <= 1'b1;
          state       <= S_IDLE;
          if (accept) begin
            wr_q  <= bus.HWRITE;
            idx_q <= idx_in;
            if (addr_err) begin
              state       <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              state <= S_DATA;
              if (!bus.HWRITE)
                hrdata_q <= (wr_commit && (idx_q == idx_in)) ? merged : mem[idx_in];
            end else begin
              state       <= S_WAIT;
              hreadyout_q <= 1'b0;
              wait_cnt    <= WS_LOAD;
            end
          end
        end
      endcase
    end
  end

  // Memory has no reset; contents are undefined until written.
  always_ff @(posedge HCLK) begin
    if (wr_commit) mem[idx_q] <= merged;
  end

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = hrdata_q;

  logic unused_ok;
  assign unused_ok = ^{bus.HBURST, bus.HMASTLOCK, bus.HTRANS[0]};

endmodule
